// File: rtl/execute_stage.sv
// execute_stage: EX pipeline stage of the 64-bit LEGv8-style CPU.
// Registers the ALU result, branch target, zero flag and pass-through
// controls into the EX/MEM boundary. MUL runs on an iterative radix-2^R
// multiplier and holds decode via stall until the product registers.
module execute_stage #(
  parameter int MUL_RADIX_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        validI,
  input  logic [31:0] InstructionI,
  input  logic [63:0] PCI,
  input  logic [63:0] Data1I,
  input  logic [63:0] Data2I,
  input  logic [63:0] ImmI,
  input  logic        ALUSrcI,
  input  logic [3:0]  ALUOpI,
  input  logic        BI,
  input  logic        BZI,
  input  logic        BNZI,
  input  logic        MemReadI,
  input  logic        MemWriteI,
  input  logic        MemToRegI,
  input  logic        RegWriteI,
  input  logic        flush,
  output logic        stall,
  output logic        validO,
  output logic [31:0] InstructionO,
  output logic [63:0] branchAddressO,
  output logic [63:0] ResultsO,
  output logic [63:0] Data2O,
  output logic        zeroO,
  output logic        BO,
  output logic        BZO,
  output logic        BNZO,
  output logic        MemReadO,
  output logic        MemWriteO,
  output logic        MemToRegO,
  output logic        RegWriteO
);

  localparam int R  = MUL_RADIX_BITS;
  localparam int N  = 64 / R;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [3:0]    OP_MUL   = 4'd8;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [63:0]   ma, mb, acc;
  logic [63:0]   bop, alu_res, pp, acc_sum, res_d;
  logic          is_mul, load, mul_start, mul_step;

  assign bop    = ALUSrcI ? ImmI : Data2I;
  assign is_mul = (ALUOpI == OP_MUL);

  // Single-cycle ALU for every opcode except MUL.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    alu_res = '0;
    case (ALUOpI)
      4'd0: alu_res = Data1I & bop;
      4'd1: alu_res = Data1I | bop;
      4'd2: alu_res = Data1I + bop;
      4'd3: alu_res = Data1I - bop;
      4'd4: alu_res = Data1I ^ bop;
      4'd5: alu_res = Data1I << bop[5:0];
      4'd6: alu_res = Data1I >> bop[5:0];
      4'd7: alu_res = bop;
      default: alu_res = '0;
    endcase
  end

  // Partial product of the multiplicand with the low R multiplier bits.
  always_comb begin
    pp = '0;
    for (int j = 0; j < R; j++) begin
      if (mb[j]) pp = pp + (ma << j);
    end
  end

  assign acc_sum = acc + pp;
  assign res_d   = (state == S_MUL) ? acc_sum : alu_res;

  // Next-state logic: flush wins over accept and completion.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    if (flush) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (validI) begin
            if (is_mul) begin
              mul_start = 1'b1;
              state_nxt = S_MUL;
              cnt_nxt   = '0;
            end else begin
              load = 1'b1;
            end
          end
        end
        S_MUL: begin
          mul_step = 1'b1;
          if (cnt == CNT_LAST) begin
            load      = 1'b1;
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Decode holds while a multiply is being accepted or is still iterating;
  // it advances on the same edge the product registers.
  assign stall = !reset && !flush &&
                 ((state == S_IDLE && validI && is_mul) ||
                  (state == S_MUL && cnt != CNT_LAST));

  // State register and iteration counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or process order.
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Multiplier datapath: latch operands on accept, shift-and-add per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ma  <= '0;
      mb  <= '0;
      acc <= '0;
    end else if (mul_start) begin
      ma  <= Data1I;
      mb  <= bop;
      acc <= '0;
    end else if (mul_step) begin
      ma  <= ma << R;
      mb  <= mb >> R;
      acc <= acc_sum;
    end
  end

  // EX/MEM register: load a finished instruction or emit a bubble, where a
  // bubble clears valid and controls but leaves the data fields untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      validO         <= 1'b0;
      InstructionO   <= '0;
      branchAddressO <= '0;
      ResultsO       <= '0;
      Data2O         <= '0;
      zeroO          <= 1'b0;
      BO             <= 1'b0;
      BZO            <= 1'b0;
      BNZO           <= 1'b0;
      MemReadO       <= 1'b0;
      MemWriteO      <= 1'b0;
      MemToRegO      <= 1'b0;
      RegWriteO      <= 1'b0;
    end else if (load) begin
      validO         <= 1'b1;
      InstructionO   <= InstructionI;
      branchAddressO <= PCI + (ImmI << 2);
      ResultsO       <= res_d;
      Data2O         <= Data2I;
      zeroO          <= (res_d == 64'd0);
      BO             <= BI;
      BZO            <= BZI;
      BNZO           <= BNZI;
      MemReadO       <= MemReadI;
      MemWriteO      <= MemWriteI;
      MemToRegO      <= MemToRegI;
      RegWriteO      <= RegWriteI;
    end else begin
      validO    <= 1'b0;
      BO        <= 1'b0;
      BZO       <= 1'b0;
      BNZO      <= 1'b0;
      MemReadO  <= 1'b0;
      MemWriteO <= 1'b0;
      MemToRegO <= 1'b0;
      RegWriteO <= 1'b0;
    end
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Pipelined execute (EX) stage of the 64-bit LEGv8-style CPU. It registers ALU results, the branch target and the zero flag into the EX/MEM boundary that feeds the memory-access stage. Single-cycle ALU operations complete in one clock. MUL runs on an iterative multiplier that stalls decode until the product is ready. A taken-branch flush from the memory stage squashes the stage.

## Interface
Parameters:
- MUL_RADIX_BITS, default 2: multiplier bits consumed per cycle; legal values 1, 2, 4; N = 64/MUL_RADIX_BITS iterations.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- validI  in  1  ID/EX holds a real instruction.
- InstructionI  in  32  instruction word; passed through (Rd = [4:0]).
- PCI  in  64  PC of the instruction.
- Data1I, Data2I  in  64 each  register-file operands Rn, Rm/Rt.
- ImmI  in  64  sign-extended immediate / branch offset (in words).
- ALUSrcI  in  1  1: operand B = ImmI; 0: operand B = Data2I.
- ALUOpI  in  4  0 AND, 1 ORR, 2 ADD, 3 SUB, 4 EOR, 5 LSL, 6 LSR, 7 PASSB, 8 MUL; 9–15 result 0.
- BI, BZI, BNZI, MemReadI, MemWriteI, MemToRegI, RegWriteI  in  1 each  control, passed through.
- flush  in  1  squash the current EX contents (PCSrc from the memory stage).
- stall  out  1  decode must hold all inputs unchanged this cycle.
- validO, InstructionO, branchAddressO[64], ResultsO[64], Data2O[64], zeroO, BO, BZO, BNZO, MemReadO, MemWriteO, MemToRegO, RegWriteO  out  registered EX/MEM outputs.

Reset is synchronous and active-high on one clock (clk/reset); it is the only reset.

## Operation
- A = Data1I; Bop = ALUSrcI ? ImmI : Data2I.
- LSL/LSR shift A by Bop[5:0], logical, with zero fill.
- PASSB passes Bop through unchanged. It is used for CBZ/CBNZ on Rt.
- ADD and SUB are mod 2^64.
- MUL returns the low 64 bits of A×Bop.
- branchAddressO = PCI + (ImmI << 2), mod 2^64.
- zeroO = (result == 0).
- Data2O = Data2I. The store data is always Data2I, never Bop.
- States: IDLE and MUL. The iteration counter cnt has range 0..N-1.
- IDLE, validI=1, non-MUL: at the edge, all outputs load from inputs and validO=1.
- IDLE, validI=1, MUL:
  - Latch mA=A, mB=Bop, acc=0, cnt=0.
  - Go to MUL.
  - Emit a bubble.
- MUL state, each cycle: acc += mA × mB[R-1:0]; mA <<= R; mB >>= R; cnt++. R = MUL_RADIX_BITS.
- MUL state, cnt = N-1: the final sum is registered into ResultsO and zeroO is set from it. All other outputs load from the held inputs, validO=1, and the state returns to IDLE.
- stall = !reset & !flush & ((IDLE & validI & ALUOpI==8) | (MUL & cnt != N-1)).
- Bubble: validO=0, and BO, BZO, BNZO, MemReadO, MemWriteO, MemToRegO, RegWriteO = 0. Data outputs hold their previous values.
- Bubbles are emitted when validI=0, on the MUL-accept edge, and during the MUL iterations before cnt = N-1.
- Flush at an edge, in either state:
  - Emit a bubble.
  - Abandon any multiply.
  - State → IDLE, cnt → 0.
  - Flush takes priority over accept and completion.
- Reset value of every output is 0, including stall, validO and InstructionO.
- After reset, state = IDLE and cnt = 0.
- Reset has priority over flush.

## Timing
- Non-MUL latency: 1 cycle. The inputs present before edge k appear on the outputs after edge k.
- Non-MUL throughput: one instruction per cycle.
- MUL latency: N+1 edges from first presentation. It is 33 cycles for R=2.
- MUL stall: stall is high for N consecutive cycles. It drops in the cycle with cnt = N-1, so decode advances on the same edge the product registers.
- The downstream stage never backpressures. The outputs change every edge.
- Reset asserted mid-multiply: the next edge clears the state, and stall is 0 in the same cycle that reset is high.

## Test plan
- ADD: Data1=5, Data2=7, ALUSrc=0, RegWrite=1 → after 1 edge ResultsO=12, zeroO=0, validO=1, RegWriteO=1, stall never high.
- SUB equal plus CBZ target:
  - SUB with Data1=Data2=0x1234 → ResultsO=0, zeroO=1.
  - PASSB with PC=0x100, Imm=-4, BZ=1 → branchAddressO=0xF0, BZO=1, zeroO per Data2.
- Shifts: LSL with A=1, Imm=63, ALUSrc=1 → 0x8000_0000_0000_0000. LSR by 64 uses only Bop[5:0]=0 → ResultsO=A.
- MUL, R=2: 3 × 0xFFFF_FFFF_FFFF_FFFF → stall high 32 cycles, validO=0 throughout, then ResultsO=0xFFFF_FFFF_FFFF_FFFD, validO=1. A following ADD completes on the very next edge.
- Flush mid-MUL: assert flush on iteration 10 → stall=0 that cycle, next edge validO=0 with all controls 0, state IDLE. A subsequent ADD completes normally.
- Reset mid-MUL, plus store pass-through:
  - Assert reset on iteration 5 → all outputs 0, stall 0.
  - After release, a store with MemWrite=1, Data2=0xDEAD → MemWriteO=1, Data2O=0xDEAD.
